uart_rx: RTL

//  - Receive side of the 8N1 UART link whose transmit side drives uart_tx_data.
//  - Oversamples the async serial line 16x from the system clock using an internal baud tick.
//  - Delivers one byte per frame with a one-cycle valid strobe plus error flags.
//  - Sits beside the transmitter in the top level; rx_data feeds downstream ADC/control logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, frame width and baud divider math.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Rounded clk / (baud * os), so the tick rate error is at most half a clock.
  function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    den = baud * os;
    return (clk + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting a one-clock tick every DIV clocks; clr restarts the phase.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LastCnt) && !clr;
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LastCnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, valid strobe and frame/parity error strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 RST_clk,
  input  logic                 rst,
  input  logic                 uart_rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MidTick  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LastTick = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LastBit  = BW'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 line;
  logic                 tick;
  logic                 tick_clr;
  logic                 mid_done;
  logic                 bit_done;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  assign line = sync_q[1];

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk (RST_clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  // START checks at mid-bit; every later state samples one full bit period after the last.
  assign mid_done = tick && (tick_cnt_q == MidTick);
  assign bit_done = tick && (tick_cnt_q == LastTick);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    ferr_d     = 1'b0;
    tick_clr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif

    if (tick) begin
      tick_cnt_d = (tick_cnt_q == LastTick) ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!line) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          tick_clr   = 1'b1;
        end
      end
      START: begin
        if (mid_done) begin
          if (line) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d    = DATA;
            tick_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {line, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          par_d   = line;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (line) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_q ^ (^shift_q);
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge RST_clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], uart_rx_in};
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
